// File: rtl/punc_datapath_hs.sv
// punc_datapath_hs
// ----------------
// Parametrised PUnC LC3 datapath. It holds the PC, the 16-bit IR, the NZP
// flags and the register file. A controller issues one command at a time
// over a valid/ready command handshake and sees completion as a one-cycle
// cmd_done pulse. Memory sits behind a valid/ready request port plus a
// response strobe, and a small FSM sequences each memory access.
//
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   cmd_valid/ready    command handshake (ready only while idle)
//   cmd_op             0 FETCH 1 ALU 2 LOAD 3 STORE 4 BRANCH 5 JMP 6 LINK 7 NOP
//   alu_fn             0 PASSB 1 ADD 2 AND 3 NOT A
//   addr_mode          0 PC+off9 1 base+off6 2 indirect PC+off9 3 LEA
//   cmd_done           one-cycle completion pulse
//   mem_req_*          request handshake: we, addr, wdata
//   mem_rsp_valid/data read response
//   ir_out, nzp_true   IR and branch condition for the controller
//   rf_debug_addr/data combinational register file debug read
//   pc_debug_data      current PC
//
// Optional feature macro: PUNC_DP_PERF_EN
//   When defined, adds perf_instr (completed FETCH count) and perf_stall
//   (cycles a memory handshake was pending), both 32-bit saturating.

module punc_datapath_hs #(
  parameter int                DATA_W   = 16,
  parameter int                NREGS    = 8,
  parameter logic [DATA_W-1:0] PC_RESET = '0,
  localparam int               RA_W     = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [1:0]        alu_fn,
  input  logic [1:0]        addr_mode,
  output logic              cmd_done,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [DATA_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic [15:0]       ir_out,
  output logic              nzp_true,
  input  logic [RA_W-1:0]   rf_debug_addr,
  output logic [DATA_W-1:0] rf_debug_data,
`ifdef PUNC_DP_PERF_EN
  output logic [DATA_W-1:0] pc_debug_data,
  output logic [31:0]       perf_instr,
  output logic [31:0]       perf_stall
`else
  output logic [DATA_W-1:0] pc_debug_data
`endif
);

  localparam logic [2:0] OP_FETCH  = 3'd0;
  localparam logic [2:0] OP_ALU    = 3'd1;
  localparam logic [2:0] OP_LOAD   = 3'd2;
  localparam logic [2:0] OP_STORE  = 3'd3;
  localparam logic [2:0] OP_BRANCH = 3'd4;
  localparam logic [2:0] OP_JMP    = 3'd5;
  localparam logic [2:0] OP_LINK   = 3'd6;
  localparam logic [2:0] OP_NOP    = 3'd7;

  localparam logic [1:0] FN_PASSB  = 2'd0;
  localparam logic [1:0] FN_ADD    = 2'd1;
  localparam logic [1:0] FN_AND    = 2'd2;

  localparam logic [1:0] AM_BASE   = 2'd1;
  localparam logic [1:0] AM_IND    = 2'd2;
  localparam logic [1:0] AM_LEA    = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_IREQ,
    S_IWAIT
  } state_t;

  // ---------------------------------------------------------------------
  // Arithmetic helpers
  // ---------------------------------------------------------------------
  function automatic logic signed [DATA_W-1:0] sext9(input logic [8:0] f);
    return {{(DATA_W-9){f[8]}}, f};
  endfunction

  function automatic logic signed [DATA_W-1:0] sext6(input logic [5:0] f);
    return {{(DATA_W-6){f[5]}}, f};
  endfunction

  function automatic logic signed [DATA_W-1:0] sext5(input logic [4:0] f);
    return {{(DATA_W-5){f[4]}}, f};
  endfunction

  // IR register fields are 3 bits; widen them to the register index width.
  function automatic logic [RA_W-1:0] ridx(input logic [2:0] f);
    logic [RA_W-1:0] r;
    r      = '0;
    r[2:0] = f;
    return r;
  endfunction

  function automatic logic [2:0] nzp_of(input logic [DATA_W-1:0] v);
    logic n, z;
    n = v[DATA_W-1];
    z = (v == '0);
    return {n, z, ~n & ~z};
  endfunction

  function automatic logic [DATA_W-1:0] alu_calc(input logic [1:0]        fn,
                                                 input logic signed [DATA_W-1:0] a,
                                                 input logic signed [DATA_W-1:0] b);
    logic signed [DATA_W-1:0] r;
    case (fn)
      FN_PASSB: r = b;
      FN_ADD:   r = a + b;
      FN_AND:   r = a & b;
      default:  r = ~a;
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------------
  // Architectural and transaction state
  // ---------------------------------------------------------------------
  state_t            state, state_next;
  logic [DATA_W-1:0] pc;
  logic [15:0]       ir;
  logic [2:0]        nzp;
  logic [DATA_W-1:0] rf [NREGS];

  // Captured at command accept so the request stays stable while stalled.
  logic [2:0]        op_r;
  logic              ind_r;
  logic [DATA_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;

  // ---------------------------------------------------------------------
  // Operand and address generation (reads see pre-write register values)
  // ---------------------------------------------------------------------
  logic signed [DATA_W-1:0] ra_val, rb_val, rs_val, alu_b;
  logic [DATA_W-1:0]        alu_res, pc_rel, base_rel, pc_inc;

  assign ra_val   = rf[ridx(ir[8:6])];
  assign rb_val   = rf[ridx(ir[2:0])];
  assign rs_val   = rf[ridx(ir[11:9])];
  assign alu_b    = ir[5] ? sext5(ir[4:0]) : rb_val;
  assign alu_res  = alu_calc(alu_fn, ra_val, alu_b);
  assign pc_rel   = pc + sext9(ir[8:0]);
  assign base_rel = ra_val + sext6(ir[5:0]);
  assign pc_inc   = pc + DATA_W'(1);

  assign nzp_true = (ir[11] & nzp[2]) | (ir[10] & nzp[1]) | (ir[9] & nzp[0]);

  // ---------------------------------------------------------------------
  // Next-state and write-strobe decode
  // ---------------------------------------------------------------------
  logic              rf_we, nzp_we, pc_we, ir_we, cap, ptr_we, done_next;
  logic [RA_W-1:0]   rf_waddr;
  logic [DATA_W-1:0] rf_wdata, pc_val;
  logic [2:0]        nzp_val;

  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    rf_we      = 1'b0;
    rf_waddr   = ridx(ir[11:9]);
    rf_wdata   = '0;
    nzp_we     = 1'b0;
    nzp_val    = nzp;
    pc_we      = 1'b0;
    pc_val     = pc;
    ir_we      = 1'b0;
    cap        = 1'b0;
    ptr_we     = 1'b0;

    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_FETCH: begin
              cap        = 1'b1;
              state_next = S_REQ;
            end
            OP_ALU: begin
              rf_we     = 1'b1;
              rf_wdata  = alu_res;
              nzp_we    = 1'b1;
              nzp_val   = nzp_of(alu_res);
              done_next = 1'b1;
            end
            OP_LOAD: begin
              if (addr_mode == AM_LEA) begin
                rf_we     = 1'b1;
                rf_wdata  = pc_rel;
                done_next = 1'b1;
              end else begin
                cap        = 1'b1;
                state_next = S_REQ;
              end
            end
            OP_STORE: begin
              // There is nothing to write for a LEA-mode store; it just completes.
              if (addr_mode == AM_LEA) begin
                done_next = 1'b1;
              end else begin
                cap        = 1'b1;
                state_next = S_REQ;
              end
            end
            OP_BRANCH: begin
              pc_we     = nzp_true;
              pc_val    = pc_rel;
              done_next = 1'b1;
            end
            OP_JMP: begin
              pc_we     = 1'b1;
              pc_val    = ra_val;
              done_next = 1'b1;
            end
            OP_LINK: begin
              rf_we     = 1'b1;
              rf_waddr  = ridx(3'd7);
              rf_wdata  = pc;
              done_next = 1'b1;
            end
            default: done_next = 1'b1;
          endcase
        end
      end

      S_REQ: begin
        if (mem_req_ready) begin
          // A direct store needs no response; an indirect store first reads its pointer.
          if (op_r == OP_STORE && !ind_r) begin
            state_next = S_IDLE;
            done_next  = 1'b1;
          end else begin
            state_next = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        if (mem_rsp_valid) begin
          if (ind_r) begin
            ptr_we     = 1'b1;
            state_next = S_IREQ;
          end else if (op_r == OP_FETCH) begin
            ir_we      = 1'b1;
            pc_we      = 1'b1;
            pc_val     = pc_inc;
            state_next = S_IDLE;
            done_next  = 1'b1;
          end else begin
            rf_we      = 1'b1;
            rf_wdata   = mem_rsp_data;
            nzp_we     = 1'b1;
            nzp_val    = nzp_of(mem_rsp_data);
            state_next = S_IDLE;
            done_next  = 1'b1;
          end
        end
      end

      S_IREQ: begin
        if (mem_req_ready) begin
          if (op_r == OP_STORE) begin
            state_next = S_IDLE;
            done_next  = 1'b1;
          end else begin
            state_next = S_IWAIT;
          end
        end
      end

      S_IWAIT: begin
        if (mem_rsp_valid) begin
          rf_we      = 1'b1;
          rf_wdata   = mem_rsp_data;
          nzp_we     = 1'b1;
          nzp_val    = nzp_of(mem_rsp_data);
          state_next = S_IDLE;
          done_next  = 1'b1;
        end
      end

      default: state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cmd_done <= 1'b0;
    end else begin
      state    <= state_next;
      cmd_done <= done_next;
    end
  end

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc      <= PC_RESET;
      ir      <= '0;
      nzp     <= 3'b010;
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
      op_r    <= OP_NOP;
      ind_r   <= 1'b0;
      addr_r  <= '0;
      wdata_r <= '0;
    end else begin
      if (pc_we)  pc  <= pc_val;
      if (ir_we)  ir  <= mem_rsp_data[15:0];
      if (nzp_we) nzp <= nzp_val;
      if (rf_we)  rf[rf_waddr] <= rf_wdata;
      if (cap) begin
        op_r    <= cmd_op;
        ind_r   <= (cmd_op != OP_FETCH) && (addr_mode == AM_IND);
        wdata_r <= rs_val;
        if (cmd_op == OP_FETCH)          addr_r <= pc;
        else if (addr_mode == AM_BASE)   addr_r <= base_rel;
        else                             addr_r <= pc_rel;
      end
      // The pointer fetched by an indirect access becomes the second address.
      if (ptr_we) addr_r <= mem_rsp_data;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs (request signals decode straight from state so reset drops them at once)
  // ---------------------------------------------------------------------
  assign cmd_ready     = (state == S_IDLE);
  assign mem_req_valid = (state == S_REQ) || (state == S_IREQ);
  assign mem_req_we    = mem_req_valid && (op_r == OP_STORE) && ((state == S_IREQ) || !ind_r);
  assign mem_req_addr  = addr_r;
  assign mem_req_wdata = wdata_r;
  assign ir_out        = ir;
  assign rf_debug_data = rf[rf_debug_addr];
  assign pc_debug_data = pc;

`ifdef PUNC_DP_PERF_EN
  logic stall_cycle, instr_done;

  assign stall_cycle = (((state == S_REQ) || (state == S_IREQ)) && !mem_req_ready) ||
                       (((state == S_WAIT) || (state == S_IWAIT)) && !mem_rsp_valid);
  assign instr_done  = (state == S_WAIT) && mem_rsp_valid && !ind_r && (op_r == OP_FETCH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_instr <= '0;
      perf_stall <= '0;
    end else begin
      if (instr_done && (perf_instr != 32'hFFFF_FFFF)) perf_instr <= perf_instr + 32'd1;
      if (stall_cycle && (perf_stall != 32'hFFFF_FFFF)) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_punc_datapath_hs.sv
// Testbench for punc_datapath_hs: directed command sequences against a
// small memory model, with hand-computed expected architectural state.

module tb_punc_datapath_hs;

  localparam logic [2:0] OP_FETCH  = 3'd0;
  localparam logic [2:0] OP_ALU    = 3'd1;
  localparam logic [2:0] OP_LOAD   = 3'd2;
  localparam logic [2:0] OP_STORE  = 3'd3;
  localparam logic [2:0] OP_BRANCH = 3'd4;
  localparam logic [2:0] OP_JMP    = 3'd5;
  localparam logic [2:0] OP_LINK   = 3'd6;
  localparam logic [2:0] OP_NOP    = 3'd7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = 3'd7;
  logic [1:0]  alu_fn = 2'd0;
  logic [1:0]  addr_mode = 2'd0;
  logic        cmd_done;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic        mem_req_we;
  logic [15:0] mem_req_addr;
  logic [15:0] mem_req_wdata;
  logic        mem_rsp_valid = 1'b0;
  logic [15:0] mem_rsp_data = 16'h0;
  logic [15:0] ir_out;
  logic        nzp_true;
  logic [2:0]  rf_debug_addr = 3'd0;
  logic [15:0] rf_debug_data;
  logic [15:0] pc_debug_data;
`ifdef PUNC_DP_PERF_EN
  logic [31:0] perf_instr;
  logic [31:0] perf_stall;
`endif

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [0:255];

  // Results of the most recent exec() call
  int          done_iter;
  int          done_cnt;
  int          n_req;
  int          valid_cycles;
  bit          unstable;
  bit          busy_ready;
  logic [15:0] req_addr  [0:3];
  logic        req_we    [0:3];
  logic [15:0] req_wdata [0:3];

  punc_datapath_hs #(.DATA_W(16), .NREGS(8), .PC_RESET(16'h0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .alu_fn        (alu_fn),
    .addr_mode     (addr_mode),
    .cmd_done      (cmd_done),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_we    (mem_req_we),
    .mem_req_addr  (mem_req_addr),
    .mem_req_wdata (mem_req_wdata),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .ir_out        (ir_out),
    .nzp_true      (nzp_true),
    .rf_debug_addr (rf_debug_addr),
    .rf_debug_data (rf_debug_data),
`ifdef PUNC_DP_PERF_EN
    .pc_debug_data (pc_debug_data),
    .perf_instr    (perf_instr),
    .perf_stall    (perf_stall)
`else
    .pc_debug_data (pc_debug_data)
`endif
  );

  always #5 clk = ~clk;

  // Issue one command and act as the memory until one cycle past cmd_done.
  // Iteration c is the c-th falling edge after the accepting rising edge.
  task automatic exec(input logic [2:0] op, input logic [1:0] fn,
                      input logic [1:0] mode, input int rdy_wait);
    int          stall;
    bit          rsp_due, seen, we0;
    logic [15:0] rsp_d, a0, w0;
    done_iter = -1; done_cnt = 0; n_req = 0; valid_cycles = 0;
    unstable = 0; busy_ready = 0;
    stall = rdy_wait; rsp_due = 0; seen = 0; we0 = 0;
    rsp_d = '0; a0 = '0; w0 = '0;
    @(negedge clk);
    cmd_op = op; alu_fn = fn; addr_mode = mode; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int c = 0; c < 40; c++) begin
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      if (cmd_done === 1'b1) begin
        done_cnt++;
        if (done_iter < 0) done_iter = c;
      end
      if (done_iter >= 0 && c == done_iter + 1) break;
      if (rsp_due) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = rsp_d;
        rsp_due       = 0;
      end
      if (mem_req_valid === 1'b1) begin
        valid_cycles++;
        if (cmd_ready !== 1'b0) busy_ready = 1;
        if (!seen) begin
          seen = 1; a0 = mem_req_addr; w0 = mem_req_wdata; we0 = mem_req_we;
        end else if (mem_req_addr !== a0 || mem_req_wdata !== w0 || mem_req_we !== we0) begin
          unstable = 1;
        end
        if (stall > 0) begin
          stall--;
        end else begin
          mem_req_ready = 1'b1;
          seen = 0;
          if (n_req < 4) begin
            req_addr[n_req] = mem_req_addr;
            req_we[n_req] = mem_req_we;
            req_wdata[n_req] = mem_req_wdata;
          end
          n_req++;
          if (mem_req_we) mem[mem_req_addr[7:0]] = mem_req_wdata;
          else begin rsp_due = 1; rsp_d = mem[mem_req_addr[7:0]]; end
        end
      end
      @(negedge clk);
    end
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (pc_debug_data !== 16'h0000) begin errors++; $display("FAIL reset_pc: got %h expected 0000", pc_debug_data); end
    checks++; if (ir_out !== 16'h0000) begin errors++; $display("FAIL reset_ir: got %h expected 0000", ir_out); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b expected 0", mem_req_valid); end
    checks++; if (cmd_done !== 1'b0) begin errors++; $display("FAIL reset_cmd_done: got %b expected 0", cmd_done); end
    checks++; if (dut.nzp !== 3'b010) begin errors++; $display("FAIL reset_nzp: got %b expected 010", dut.nzp); end
    for (int r = 0; r < 8; r++) begin
      rf_debug_addr = 3'(r); #1;
      checks++; if (rf_debug_data !== 16'h0000) begin errors++; $display("FAIL reset_r%0d: got %h expected 0000", r, rf_debug_data); end
    end
  endtask

  task automatic test_fetch();
    // addr_mode 3 is passed deliberately: a fetch always addresses via the PC.
    exec(OP_FETCH, 2'd0, 2'd3, 0);
    checks++; if (ir_out !== 16'h1261) begin errors++; $display("FAIL fetch_ir: got %h expected 1261", ir_out); end
    checks++; if (pc_debug_data !== 16'h0001) begin errors++; $display("FAIL fetch_pc: got %h expected 0001", pc_debug_data); end
    checks++; if (n_req !== 1 || req_addr[0] !== 16'h0000 || req_we[0] !== 1'b0) begin errors++; $display("FAIL fetch_req: got n=%0d addr=%h we=%b expected n=1 addr=0000 we=0", n_req, req_addr[0], req_we[0]); end
    checks++; if (done_iter !== 2 || done_cnt !== 1) begin errors++; $display("FAIL fetch_done: got at=%0d count=%0d expected at=2 count=1", done_iter, done_cnt); end
    checks++; if (busy_ready !== 1'b0) begin errors++; $display("FAIL fetch_busy_ready: got %b expected 0", busy_ready); end
  endtask

  task automatic test_alu();
    // IR=1261: Rd=R1, A=R1, imm=+1
    exec(OP_ALU, 2'd3, 2'd0, 0);   // NOT R1 -> FFFF
    rf_debug_addr = 3'd1; #1;
    checks++; if (rf_debug_data !== 16'hFFFF || dut.nzp !== 3'b100) begin errors++; $display("FAIL alu_not: got r1=%h nzp=%b expected r1=ffff nzp=100", rf_debug_data, dut.nzp); end
    checks++; if (done_iter !== 0 || done_cnt !== 1) begin errors++; $display("FAIL alu_done: got at=%0d count=%0d expected at=0 count=1", done_iter, done_cnt); end
    exec(OP_ALU, 2'd1, 2'd0, 0);   // FFFF + 1 wraps to 0
    rf_debug_addr = 3'd1; #1;
    checks++; if (rf_debug_data !== 16'h0000 || dut.nzp !== 3'b010) begin errors++; $display("FAIL alu_add_wrap: got r1=%h nzp=%b expected r1=0000 nzp=010", rf_debug_data, dut.nzp); end
    exec(OP_FETCH, 2'd0, 2'd0, 0); // IR=1262, PC=2
    exec(OP_ALU, 2'd1, 2'd0, 0);   // R1 = 0 + 2
    rf_debug_addr = 3'd1; #1;
    checks++; if (rf_debug_data !== 16'h0002 || dut.nzp !== 3'b001) begin errors++; $display("FAIL alu_add_pos: got r1=%h nzp=%b expected r1=0002 nzp=001", rf_debug_data, dut.nzp); end
    checks++; if (nzp_true !== 1'b1) begin errors++; $display("FAIL alu_nzp_true: got %b expected 1", nzp_true); end
  endtask

  task automatic test_load_indirect();
    exec(OP_FETCH, 2'd0, 2'd0, 0);  // IR=0E0C, PC=3
    exec(OP_BRANCH, 2'd0, 2'd0, 0); // unconditional +12 -> PC=000F
    checks++; if (pc_debug_data !== 16'h000F) begin errors++; $display("FAIL br_setup_pc: got %h expected 000f", pc_debug_data); end
    exec(OP_FETCH, 2'd0, 2'd0, 0);  // IR=A602 (R3, off 2), PC=0010
    exec(OP_LOAD, 2'd0, 2'd2, 0);
    checks++; if (n_req !== 2 || req_addr[0] !== 16'h0012 || req_addr[1] !== 16'h0040) begin errors++; $display("FAIL ldi_reqs: got n=%0d a0=%h a1=%h expected n=2 a0=0012 a1=0040", n_req, req_addr[0], req_addr[1]); end
    rf_debug_addr = 3'd3; #1;
    checks++; if (rf_debug_data !== 16'h8000 || dut.nzp !== 3'b100) begin errors++; $display("FAIL ldi_result: got r3=%h nzp=%b expected r3=8000 nzp=100", rf_debug_data, dut.nzp); end
    checks++; if (done_iter !== 4 || pc_debug_data !== 16'h0010) begin errors++; $display("FAIL ldi_done: got at=%0d pc=%h expected at=4 pc=0010", done_iter, pc_debug_data); end
  endtask

  task automatic test_store_stall();
    exec(OP_STORE, 2'd0, 2'd0, 5);  // R3=8000 to PC+2=0012
    checks++; if (valid_cycles !== 6 || unstable !== 1'b0) begin errors++; $display("FAIL st_stable: got cycles=%0d unstable=%b expected cycles=6 unstable=0", valid_cycles, unstable); end
    checks++; if (req_addr[0] !== 16'h0012 || req_we[0] !== 1'b1 || req_wdata[0] !== 16'h8000) begin errors++; $display("FAIL st_req: got addr=%h we=%b data=%h expected addr=0012 we=1 data=8000", req_addr[0], req_we[0], req_wdata[0]); end
    checks++; if (done_iter !== 6 || done_cnt !== 1) begin errors++; $display("FAIL st_done: got at=%0d count=%0d expected at=6 count=1", done_iter, done_cnt); end
    checks++; if (dut.nzp !== 3'b100) begin errors++; $display("FAIL st_nzp: got %b expected 100", dut.nzp); end
  endtask

  task automatic test_lea_and_base();
    exec(OP_LOAD, 2'd0, 2'd3, 0);   // LEA R3 = 0010 + 2
    rf_debug_addr = 3'd3; #1;
    checks++; if (rf_debug_data !== 16'h0012 || dut.nzp !== 3'b100 || n_req !== 0) begin errors++; $display("FAIL lea: got r3=%h nzp=%b reqs=%0d expected r3=0012 nzp=100 reqs=0", rf_debug_data, dut.nzp, n_req); end
    exec(OP_LOAD, 2'd0, 2'd1, 0);   // R3 = mem[R0 + 2] = 0E0C
    rf_debug_addr = 3'd3; #1;
    checks++; if (req_addr[0] !== 16'h0002 || rf_debug_data !== 16'h0E0C || dut.nzp !== 3'b001) begin errors++; $display("FAIL ld_base: got addr=%h r3=%h nzp=%b expected addr=0002 r3=0e0c nzp=001", req_addr[0], rf_debug_data, dut.nzp); end
  endtask

  task automatic test_branch();
    exec(OP_FETCH, 2'd0, 2'd0, 0);  // IR=0FF3, PC=0011
    exec(OP_BRANCH, 2'd0, 2'd0, 0); // -13 -> PC=0004
    exec(OP_FETCH, 2'd0, 2'd0, 0);  // IR=0BFE, PC=0005
    exec(OP_ALU, 2'd2, 2'd0, 0);    // R5 = R7 & FFFE = 0 -> NZP=010
    rf_debug_addr = 3'd5; #1;
    checks++; if (rf_debug_data !== 16'h0000 || nzp_true !== 1'b0) begin errors++; $display("FAIL br_and: got r5=%h nzp_true=%b expected r5=0000 nzp_true=0", rf_debug_data, nzp_true); end
    exec(OP_BRANCH, 2'd0, 2'd0, 0);
    checks++; if (pc_debug_data !== 16'h0005) begin errors++; $display("FAIL br_not_taken: got pc=%h expected 0005", pc_debug_data); end
    exec(OP_ALU, 2'd3, 2'd0, 0);    // R5 = ~R7 = FFFF -> NZP=100
    exec(OP_BRANCH, 2'd0, 2'd0, 0);
    checks++; if (pc_debug_data !== 16'h0003) begin errors++; $display("FAIL br_taken: got pc=%h expected 0003", pc_debug_data); end
  endtask

  task automatic test_link_jmp_nop();
    exec(OP_LINK, 2'd0, 2'd0, 0);   // R7 = 0003
    rf_debug_addr = 3'd7; #1;
    checks++; if (rf_debug_data !== 16'h0003) begin errors++; $display("FAIL link: got r7=%h expected 0003", rf_debug_data); end
    exec(OP_BRANCH, 2'd0, 2'd0, 0); // PC = 0001
    exec(OP_JMP, 2'd0, 2'd0, 0);    // PC = R7
    checks++; if (pc_debug_data !== 16'h0003) begin errors++; $display("FAIL jmp: got pc=%h expected 0003", pc_debug_data); end
    exec(OP_NOP, 2'd0, 2'd0, 0);
    checks++; if (done_iter !== 0 || done_cnt !== 1 || pc_debug_data !== 16'h0003) begin errors++; $display("FAIL nop: got at=%0d count=%0d pc=%h expected at=0 count=1 pc=0003", done_iter, done_cnt, pc_debug_data); end
  endtask

  task automatic test_reset_mid();
    int dones;
    // Reset while a request is pending
    @(negedge clk); cmd_op = OP_FETCH; addr_mode = 2'd0; cmd_valid = 1'b1;
    @(negedge clk); cmd_valid = 1'b0; mem_req_ready = 1'b0;
    checks++; if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL rst_req_pending: got %b expected 1", mem_req_valid); end
    #2 rst = 1'b1; #1;
    checks++; if (mem_req_valid !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_async_req: got valid=%b ready=%b expected valid=0 ready=1", mem_req_valid, cmd_ready); end
    @(negedge clk); rst = 1'b0;
    // Reset while waiting for read data, then a stray response
    @(negedge clk); cmd_op = OP_FETCH; cmd_valid = 1'b1;
    @(negedge clk); cmd_valid = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk); mem_req_ready = 1'b0;
    checks++; if (cmd_ready !== 1'b0 || mem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_in_wait: got ready=%b valid=%b expected ready=0 valid=0", cmd_ready, mem_req_valid); end
    #2 rst = 1'b1; #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_async_idle: got ready=%b expected 1", cmd_ready); end
    @(negedge clk); rst = 1'b0;
    mem_rsp_valid = 1'b1; mem_rsp_data = 16'hBEEF;
    dones = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (cmd_done !== 1'b0) dones++;
    end
    mem_rsp_valid = 1'b0;
    checks++; if (dones !== 0) begin errors++; $display("FAIL rst_stray_done: got %0d pulses expected 0", dones); end
    rf_debug_addr = 3'd1; #1;
    checks++; if (ir_out !== 16'h0000 || pc_debug_data !== 16'h0000 || rf_debug_data !== 16'h0000 || dut.nzp !== 3'b010) begin errors++; $display("FAIL rst_stray_state: got ir=%h pc=%h r1=%h nzp=%b expected ir=0000 pc=0000 r1=0000 nzp=010", ir_out, pc_debug_data, rf_debug_data, dut.nzp); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h00] = 16'h1261;  // ADD R1,R1,#1
    mem[8'h01] = 16'h1262;  // ADD R1,R1,#2
    mem[8'h02] = 16'h0E0C;  // BRnzp +12
    mem[8'h0F] = 16'hA602;  // LDI R3, +2
    mem[8'h10] = 16'h0FF3;  // BRnzp -13
    mem[8'h12] = 16'h0040;
    mem[8'h40] = 16'h8000;
    mem[8'h04] = 16'h0BFE;  // BRnp -2
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_fetch();
    test_alu();
    test_load_indirect();
    test_store_stall();
    test_lea_and_base();
    test_branch();
    test_link_jmp_nop();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
